pll_clkgen_multi: RTL

//  Parametrised multi-channel clock generator; successor to the fixed single-output 50->5 MHz PLL wrapper.

---
 rtl/pll_clkgen_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pll_clkgen_multi.sv
// pll_clkgen_multi: multi-channel programmable clock divider with
// per-channel clock-enable strobes and a lock indicator.
//
// Ports:
//   refclk     in   1        sole clock, rising edge
//   rst        in   1        synchronous reset, active-low
//   cfg_valid  in   1        config request valid
//   cfg_ready  out  1        config slot free
//   cfg_ch     in   CH_W     target channel
//   cfg_div    in   DIV_W    divide ratio (0 = disable)
//   cfg_phase  in   DIV_W    counter preload on apply
//   outclk     out  NUM_CH   registered divided clocks
//   outce      out  NUM_CH   one-cycle strobe per period
//   locked     out  1        all channels stable
module pll_clkgen_multi #(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = 16,
    parameter  int DEFAULT_DIV = 10,
    parameter  int LOCK_CYCLES = 64,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outce,
    output logic              locked
);

    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
    localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_CYCLES);
    localparam logic [LK_W-1:0]  LK_ONE  = LK_W'(1);
    localparam logic [CH_W:0]    CH_LIM  = NUM_CH[CH_W:0];

    typedef struct packed {
        logic             vld;
        logic             real_ch;
        logic [CH_W-1:0]  ch;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] phase;
    } cfg_req_t;

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    cfg_req_t          req_q;
    logic [LK_W-1:0]   lock_cnt;

    logic              xfer;
    logic              xfer_real;
    logic              apply;
    logic              req_blocks_lock;
    logic [DIV_W-1:0]  phase_ld;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] apply_ch;

    always_comb begin
        xfer      = cfg_valid & cfg_ready;
        xfer_real = xfer & ({1'b0, cfg_ch} < CH_LIM);

        // Out-of-range phase falls back to a clean start of period.
        phase_ld = (req_q.phase < req_q.div) ? req_q.phase : '0;

        wrap     = '0;
        hit      = '0;
        apply_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i] = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - ONE);
            hit[i]  = req_q.vld && req_q.real_ch &&
                      (req_q.ch == CH_W'(i));
            // Wait for the old period to finish; a disabled or
            // div=1 channel has no period to protect.
            apply_ch[i] = hit[i] && ((div_q[i] <= ONE) || wrap[i]);
        end

        // Discarded requests retire on the first edge they are seen.
        apply = req_q.vld && (!req_q.real_ch || (|apply_ch));

        req_blocks_lock = req_q.vld && req_q.real_ch;
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
            outclk    <= '0;
            outce     <= '0;
            req_q     <= '0;
            cfg_ready <= 1'b0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Outputs decode the pre-edge counter, so they
                // trail the counter by exactly one cycle.
                if (div_q[i] >= TWO) begin
                    outclk[i] <= (cnt_q[i] < (div_q[i] >> 1));
                end else begin
                    outclk[i] <= (div_q[i] == ONE);
                end
                outce[i] <= wrap[i];

                if (apply_ch[i]) begin
                    div_q[i] <= req_q.div;
                    cnt_q[i] <= phase_ld;
                end else if ((div_q[i] == '0) || wrap[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + ONE;
                end
            end

            // Slot stays busy through the apply edge, free after.
            cfg_ready <= !req_q.vld && !xfer;

            if (xfer) begin
                req_q.vld     <= 1'b1;
                req_q.real_ch <= xfer_real;
                req_q.ch      <= cfg_ch;
                req_q.div     <= cfg_div;
                req_q.phase   <= cfg_phase;
            end else if (apply) begin
                req_q.vld <= 1'b0;
            end

            // A new real request restarts settling; the counter
            // only runs once nothing is waiting to change.
            if (xfer_real || req_blocks_lock) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                if (lock_cnt != LK_MAX) begin
                    lock_cnt <= lock_cnt + LK_ONE;
                end
                locked <= (lock_cnt >= LK_MAX - LK_ONE);
            end
        end
    end

endmodule
